// File: rtl/global_history_tracker.sv
// Speculative global branch history register with per-stage checkpoints
// (D/E/M), E-stage misprediction repair and a committed copy used to
// recover from traps.
module global_history_tracker #(
   parameter int k = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         StallF,
   input  logic         StallD,
   input  logic         StallE,
   input  logic         StallM,
   input  logic         FlushD,
   input  logic         FlushE,
   input  logic         FlushM,
   input  logic         PredBranchF,
   input  logic         PredDirF,
   input  logic         BranchE,
   input  logic         PCSrcE,
   input  logic         BranchM,
   input  logic         PCSrcM,
   input  logic         RestoreHistoryW,
   output logic [k-1:0] GHRF,
   output logic [k-1:0] GHRM,
   output logic [k-1:0] GHRCommit,
   output logic         RepairE
);

   logic [k-1:0] r_spec_ghr;
   logic [k-1:0] r_commit_ghr;

   // Checkpoints: history seen at lookup, predicted-branch flag, predicted direction.
   logic [k-1:0] r_hist_d, r_hist_e, r_hist_m;
   logic         r_pb_d, r_pb_e, r_pb_m;
   logic         r_pd_d, r_pd_e, r_pd_m;

   logic         w_shift_f;
   logic         w_repair;
   logic         w_commit_en;
   logic [k-1:0] w_commit_next;
   logic [k-1:0] w_spec_next;

   // Next-state selection: restore beats repair beats speculative shift.
   // The restore value includes a same-cycle commit shift so a trap taken
   // while a branch retires does not lose that branch's outcome.
   always_comb begin
      w_shift_f     = PredBranchF & ~StallF;
      w_repair      = BranchE & ~StallE & ~FlushE & (~r_pb_e | (r_pd_e != PCSrcE));
      w_commit_en   = BranchM & ~StallM & ~FlushM;
      w_commit_next = r_commit_ghr;
      if (w_commit_en)
         w_commit_next = {r_commit_ghr[k-2:0], PCSrcM};
      w_spec_next = r_spec_ghr;
      if (RestoreHistoryW)
         w_spec_next = w_commit_next;
      else if (w_repair)
         w_spec_next = {r_hist_e[k-2:0], PCSrcE};
      else if (w_shift_f)
         w_spec_next = {r_spec_ghr[k-2:0], PredDirF};
   end

   // Speculative and committed history registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_spec_ghr   <= '0;
         r_commit_ghr <= '0;
      end else begin
         r_spec_ghr   <= w_spec_next;
         r_commit_ghr <= w_commit_next;
      end
   end

   // D checkpoint: snapshot of the history used by the instruction leaving F.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist_d <= '0;
         r_pb_d   <= 1'b0;
         r_pd_d   <= 1'b0;
      end else if (FlushD) begin
         r_hist_d <= '0;
         r_pb_d   <= 1'b0;
         r_pd_d   <= 1'b0;
      end else if (!StallD) begin
         r_hist_d <= r_spec_ghr;
         r_pb_d   <= PredBranchF;
         r_pd_d   <= PredDirF;
      end
   end

   // E checkpoint: advances from D; flush wins over the enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist_e <= '0;
         r_pb_e   <= 1'b0;
         r_pd_e   <= 1'b0;
      end else if (FlushE) begin
         r_hist_e <= '0;
         r_pb_e   <= 1'b0;
         r_pd_e   <= 1'b0;
      end else if (!StallE) begin
         r_hist_e <= r_hist_d;
         r_pb_e   <= r_pb_d;
         r_pd_e   <= r_pd_d;
      end
   end

   // M checkpoint: advances from E; its history indexes the predictor update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist_m <= '0;
         r_pb_m   <= 1'b0;
         r_pd_m   <= 1'b0;
      end else if (FlushM) begin
         r_hist_m <= '0;
         r_pb_m   <= 1'b0;
         r_pd_m   <= 1'b0;
      end else if (!StallM) begin
         r_hist_m <= r_hist_e;
         r_pb_m   <= r_pb_e;
         r_pd_m   <= r_pd_e;
      end
   end

   assign GHRF      = r_spec_ghr;
   assign GHRM      = r_hist_m;
   assign GHRCommit = r_commit_ghr;
   assign RepairE   = w_repair;

endmodule

// File: tb/tb_global_history_tracker.sv
// Bench for global_history_tracker with k=4: directed scenarios plus
// randomized cycles checked against a behavioural model through a scoreboard.
module tb_global_history_tracker;
  localparam int K = 4;
  localparam int W = 3*K + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM;
  logic PredBranchF, PredDirF, BranchE, PCSrcE, BranchM, PCSrcM, RestoreHistoryW;
  logic [K-1:0] GHRF, GHRM, GHRCommit;
  logic RepairE;

  global_history_tracker #(.k(K)) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .PredBranchF(PredBranchF), .PredDirF(PredDirF),
    .BranchE(BranchE), .PCSrcE(PCSrcE), .BranchM(BranchM), .PCSrcM(PCSrcM),
    .RestoreHistoryW(RestoreHistoryW),
    .GHRF(GHRF), .GHRM(GHRM), .GHRCommit(GHRCommit), .RepairE(RepairE)
  );

  typedef struct packed {
    logic sf, sd, se, sm, fd, fe, fm, pbf, pdf, be, pce, bm, pcm, rw;
  } stim_t;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Pipeline modelled as an array of in-flight records: index 0 = D, 1 = E, 2 = M.
  int m_spec, m_commit;
  int m_hist[3];
  int m_pb[3];
  int m_pd[3];

  function automatic int push_bit(input int h, input int b);
    return ((h * 2) + b) % (1 << K);
  endfunction

  function automatic void model_reset();
    m_spec = 0;
    m_commit = 0;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = 0; m_pb[i] = 0; m_pd[i] = 0;
    end
  endfunction

  function automatic int model_repair(input stim_t s);
    if (!s.be || s.se || s.fe) return 0;
    if (m_pb[1] == 0) return 1;
    return (m_pd[1] != int'(s.pce)) ? 1 : 0;
  endfunction

  function automatic void model_step(input stim_t s);
    int commit_new, spec_new;
    commit_new = m_commit;
    if (s.bm && !s.sm && !s.fm) commit_new = push_bit(m_commit, int'(s.pcm));
    spec_new = m_spec;
    if (s.rw) spec_new = commit_new;
    else if (model_repair(s) != 0) spec_new = push_bit(m_hist[1], int'(s.pce));
    else if (s.pbf && !s.sf) spec_new = push_bit(m_spec, int'(s.pdf));
    // Advance the pipe oldest-first so each stage reads its predecessor's old record.
    if (s.fm) begin m_hist[2] = 0; m_pb[2] = 0; m_pd[2] = 0; end
    else if (!s.sm) begin m_hist[2] = m_hist[1]; m_pb[2] = m_pb[1]; m_pd[2] = m_pd[1]; end
    if (s.fe) begin m_hist[1] = 0; m_pb[1] = 0; m_pd[1] = 0; end
    else if (!s.se) begin m_hist[1] = m_hist[0]; m_pb[1] = m_pb[0]; m_pd[1] = m_pd[0]; end
    if (s.fd) begin m_hist[0] = 0; m_pb[0] = 0; m_pd[0] = 0; end
    else if (!s.sd) begin m_hist[0] = m_spec; m_pb[0] = int'(s.pbf); m_pd[0] = int'(s.pdf); end
    m_spec = spec_new;
    m_commit = commit_new;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Called at posedge+1: drive one cycle, queue its expected outputs, step the model.
  task automatic apply(input stim_t s);
    logic [W-1:0] e;
    {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, PredBranchF, PredDirF,
     BranchE, PCSrcE, BranchM, PCSrcM, RestoreHistoryW} = s;
    e = {1'(model_repair(s)), K'(m_spec), K'(m_hist[2]), K'(m_commit)};
    exp_q.push_back(e);
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  function automatic stim_t branch_f(input logic dir);
    stim_t s;
    s = '0;
    s.pbf = 1'b1;
    s.pdf = dir;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.sf  = ($urandom_range(0, 4) == 0);
    s.sd  = ($urandom_range(0, 4) == 0);
    s.se  = ($urandom_range(0, 4) == 0);
    s.sm  = ($urandom_range(0, 4) == 0);
    s.fd  = ($urandom_range(0, 7) == 0);
    s.fe  = ($urandom_range(0, 7) == 0);
    s.fm  = ($urandom_range(0, 7) == 0);
    s.pbf = 1'($urandom_range(0, 1));
    s.pdf = 1'($urandom_range(0, 1));
    s.be  = 1'($urandom_range(0, 1));
    s.pce = 1'($urandom_range(0, 1));
    s.bm  = 1'($urandom_range(0, 1));
    s.pcm = 1'($urandom_range(0, 1));
    s.rw  = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {RepairE, GHRF, GHRM, GHRCommit};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL sb {RepairE,GHRF,GHRM,GHRCommit} got=%h exp=%h", a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, PredBranchF, PredDirF,
     BranchE, PCSrcE, BranchM, PCSrcM, RestoreHistoryW} = '0;
    reset = 1'b0;
    model_reset();
    #12;
    check("reset_GHRF", int'(GHRF), 0);
    check("reset_GHRM", int'(GHRM), 0);
    check("reset_GHRCommit", int'(GHRCommit), 0);
    check("reset_RepairE", int'(RepairE), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Three predicted branches T, N, T.
    apply(branch_f(1'b1));
    check("ttn_1", int'(GHRF), 4'b0001);
    apply(branch_f(1'b0));
    check("ttn_2", int'(GHRF), 4'b0010);
    apply(branch_f(1'b1));
    check("ttn_3", int'(GHRF), 4'b0101);
    // E holds the N-predicted branch (Hist_E=0001); it resolves taken while F
    // also predicts a branch: repair wins and the F shift is dropped.
    s = branch_f(1'b1);
    s.be = 1'b1;
    s.pce = 1'b1;
    {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, PredBranchF, PredDirF,
     BranchE, PCSrcE, BranchM, PCSrcM, RestoreHistoryW} = s;
    #1;
    check("repair_comb", int'(RepairE), 1);
    apply(s);
    check("repair_next", int'(GHRF), 4'b0011);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) apply(rand_stim());

    // Fill history with ones, then assert reset between edges.
    for (int i = 0; i < K; i++) apply(branch_f(1'b1));
    check("ones_GHRF", int'(GHRF), 4'b1111);
    #2;
    reset = 1'b0;
    #1;
    check("async_GHRF", int'(GHRF), 0);
    check("async_GHRM", int'(GHRM), 0);
    check("async_GHRCommit", int'(GHRCommit), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 500; i++) apply(rand_stim());

    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/global_history_tracker.md
# global_history_tracker

Speculative global branch history register (GHR) with pipelined checkpoints and misprediction repair. It sits directly upstream of the direction-predictor tables. Each fetch cycle it supplies the history that a gshare/global-indexed predictor XORs into its table index. It also carries each branch's lookup-time history down the pipe, so the predictor update in M uses the same index as the lookup in F. Wrong-direction or unpredicted branches resolved in E restore the history. Traps restore it from the committed copy.

## Interface
- `k`, default 10: history length in bits; must be ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: reset is asynchronous and active-low.
- `StallF`, `StallD`, `StallE`, `StallM`  in  1 each: per-stage hold.
- `FlushD`, `FlushE`, `FlushM`  in  1 each: per-stage kill.
- `PredBranchF`  in  1: fetch-stage class prediction says the instruction is a conditional branch.
- `PredDirF`  in  1: predicted direction, taken = 1 (BPDirF[1] of the predictor).
- `BranchE`  in  1: the E-stage instruction is a conditional branch.
- `PCSrcE`  in  1: actual direction of the E-stage branch.
- `BranchM`  in  1: the M-stage instruction is a conditional branch.
- `PCSrcM`  in  1: actual direction of the M-stage branch.
- `RestoreHistoryW`  in  1: trap/exception redirect; reload speculative history from the committed history.
- `GHRF`  out  k: current speculative history, used for the F lookup index.
- `GHRM`  out  k: history snapshot belonging to the M-stage instruction, used for the update index.
- `GHRCommit`  out  k: architecturally committed history.
- `RepairE`  out  1: history repair occurring this cycle (debug/perf counter).

## Operation
- State:
  - speculative register `SpecGHR`, which drives `GHRF`.
  - committed register `CommitGHR`, which drives `GHRCommit`.
  - per-stage checkpoint registers D/E/M, each holding:
    - `Hist[k-1:0]`: history before this instruction's own bit.
    - `PB`: predicted-branch flag.
    - `PD`: predicted direction.
- Checkpoint pipe:
  - D captures `{SpecGHR, PredBranchF, PredDirF}` when `~StallD`.
  - E captures from D when `~StallE`.
  - M captures from E when `~StallM`.
  - A stage's flush clears its checkpoint to all-zero; flush has priority over enable.
  - A stalled stage holds its checkpoint.
- Speculative shift:
  - ShiftF = `PredBranchF & ~StallF`.
  - On ShiftF: `SpecGHR <= {SpecGHR[k-2:0], PredDirF}`.
- Repair:
  - `RepairE = BranchE & ~StallE & ~FlushE & (~PB_E | (PD_E != PCSrcE))`.
  - On repair: `SpecGHR <= {Hist_E[k-2:0], PCSrcE}`.
  - An unpredicted branch resolving not-taken also repairs. Younger in-flight checkpoints are not corrected; this costs accuracy only and is accepted.
- Commit:
  - When `BranchM & ~StallM & ~FlushM`: `CommitGHR <= {CommitGHR[k-2:0], PCSrcM}`.
- Restore:
  - When `RestoreHistoryW`: `SpecGHR <= CommitGHR`, using the value including any same-cycle commit shift.
- Priority on `SpecGHR`: restore > repair > speculative shift > hold.
  - Repair beats a same-cycle F shift because the F instruction is being squashed.
- `GHRM` = `Hist_M`, combinational from the M checkpoint.
- Shifts drop the MSB and insert at the LSB; there is no other arithmetic.

## Timing
- Reset (`reset` low, asynchronous): `SpecGHR`, `CommitGHR` and all checkpoints are 0. Consequently `GHRF`, `GHRM` and `GHRCommit` are 0 and `RepairE` is 0.
- Reset release takes effect at the next clock edge; there is no post-reset delay.
- Reset asserted mid-operation clears everything immediately, independent of `clk`.
- Latencies:
  - Shift/repair/restore results are visible on `GHRF` one cycle after the triggering edge.
  - `RepairE` is combinational in the same cycle as the E resolution.
- `GHRM` for an instruction equals the `GHRF` value present in the cycle it left F, provided there were no intervening flushes. This holds through any number of stall cycles.
- `StallE` high suppresses repair until the stall drops. Repair then fires exactly once, in the cycle E advances.

## Test plan
Concrete values below use k=4.
- Reset, then 3 predicted branches with directions T,N,T and no stalls → `GHRF` = 0001, 0010, 0101 on successive cycles.
- `SpecGHR`=0101; E branch has `Hist_E`=0010, `PD_E`=1, `PCSrcE`=0; same-cycle `PredBranchF`=1 → `RepairE`=1 and next `GHRF`=0100, not 1011.
- Branch fetched with `GHRF`=0110, then `StallD` held 3 cycles, then it flows to M → `GHRM`=0110. An E-stage flush of it yields a checkpoint of 0000 at M.
- `CommitGHR`=0011, `BranchM`=1, `PCSrcM`=1 and `RestoreHistoryW`=1 together with `RepairE`=1 → next `SpecGHR`=`GHRCommit`=0111.
- Unpredicted branch (`PB_E`=0) resolves not-taken with `Hist_E`=1000 → `RepairE`=1 and next `GHRF`=0000.
- `reset` pulled low between clock edges while `GHRF`=1111 → all outputs 0 before the next edge.
